sobel_bus_feeder: RTL and testbench

//  Bus-side producer for the mcu's bus_data_ready/load_enable handshake in the Sobel edge detector.

---
 rtl/sobel_bus_feeder.sv | 86 ++++++++
 tb/tb_sobel_bus_feeder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_bus_feeder.sv
// Packs NPIX bus pixels into one window word and offers it to the mcu on a
// bus_data_ready/load_enable level handshake, double-buffered so the bus keeps streaming.
module sobel_bus_feeder #(
  parameter int DATA_W = 8,
  parameter int NPIX   = 9,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   bus_valid,
  input  logic [DATA_W-1:0]      bus_data,
  output logic                   bus_ready,
  input  logic                   load_enable,
  output logic                   bus_data_ready,
  output logic [NPIX*DATA_W-1:0] window_out,
  output logic [CNT_W-1:0]       win_count,
  output logic                   spurious_load
);

  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int WIN_W = NPIX * DATA_W;

  // Bus handshake: a pixel transfers on any edge where bus_valid && bus_ready.
  // bus_ready depends only on registered state, never on bus_valid.
  logic [WIN_W-1:0] acc;
  logic [WIN_W-1:0] acc_nxt;
  logic [IDX_W-1:0] idx;
  logic             acc_full;
  logic             accept;
  logic             consume;
  logic             last;
  logic             hold_free;

  assign bus_ready = !acc_full;
  assign accept    = bus_valid && !acc_full;
  assign consume   = load_enable && bus_data_ready;
  assign last      = accept && (idx == IDX_W'(NPIX - 1));
  assign hold_free = !bus_data_ready || consume;

  // Accumulator including the pixel arriving this cycle, so a completed
  // window can move straight into the hold register on the same edge.
  always_comb begin
    acc_nxt = acc;
    if (accept) acc_nxt[idx*DATA_W +: DATA_W] = bus_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc            <= '0;
      idx            <= '0;
      acc_full       <= 1'b0;
      window_out     <= '0;
      bus_data_ready <= 1'b0;
      win_count      <= '0;
      spurious_load  <= 1'b0;
    end else if (clear) begin
      idx            <= '0;
      acc_full       <= 1'b0;
      bus_data_ready <= 1'b0;
      win_count      <= '0;
      spurious_load  <= 1'b0;
    end else begin
      acc <= acc_nxt;
      if (consume) win_count <= win_count + CNT_W'(1);
      if (load_enable && !bus_data_ready) spurious_load <= 1'b1;

      if (acc_full && consume) begin
        // Parked window replaces the consumed one; bus_data_ready stays high.
        window_out <= acc;
        acc_full   <= 1'b0;
        idx        <= '0;
      end else if (last && hold_free) begin
        window_out     <= acc_nxt;
        bus_data_ready <= 1'b1;
        idx            <= '0;
      end else if (last) begin
        acc_full <= 1'b1;
      end else begin
        if (accept) idx <= idx + IDX_W'(1);
        if (consume) bus_data_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_bus_feeder.sv
// Directed bench for sobel_bus_feeder: streaming, back-pressure, same-edge reload,
// spurious loads, clear, mid-window reset, and a longer randomised stream.
module tb_sobel_bus_feeder;

  localparam int WIN_W = 72;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             clear;
  logic             bus_valid;
  logic [7:0]       bus_data;
  logic             bus_ready;
  logic             load_enable;
  logic             bus_data_ready;
  logic [WIN_W-1:0] window_out;
  logic [15:0]      win_count;
  logic             spurious_load;

  int checks = 0;
  int errors = 0;

  logic [WIN_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  sobel_bus_feeder dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear          (clear),
    .bus_valid      (bus_valid),
    .bus_data       (bus_data),
    .bus_ready      (bus_ready),
    .load_enable    (load_enable),
    .bus_data_ready (bus_data_ready),
    .window_out     (window_out),
    .win_count      (win_count),
    .spurious_load  (spurious_load)
  );

  task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, let the posedge happen, sample 1ns later.
  task automatic step(input logic v, input logic [7:0] d, input logic ld, input logic clr);
    @(negedge clk);
    bus_valid   = v;
    bus_data    = d;
    load_enable = ld;
    clear       = clr;
    @(posedge clk);
    #1;
    bus_valid   = 1'b0;
    load_enable = 1'b0;
    clear       = 1'b0;
  endtask

  initial begin
    logic [WIN_W-1:0] build;
    logic [7:0]       pix;
    int               cnt;
    int               consumed;
    logic             v;
    logic             ld;
    logic             acc_ok;

    n_rst = 1'b0; clear = 1'b0; bus_valid = 1'b0; bus_data = '0; load_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bdr", bus_data_ready, 0);
    chk("rst_window", window_out, 0);
    chk("rst_count", win_count, 0);
    chk("rst_spurious", spurious_load, 0);
    chk("rst_ready", bus_ready, 1);
    @(negedge clk);
    n_rst = 1'b1;

    // T1: one full window, no consumer
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i < 9) chk("t1_bdr_low", bus_data_ready, 0);
      chk("t1_ready", bus_ready, 1);
    end
    chk("t1_bdr", bus_data_ready, 1);
    chk("t1_window", window_out, 72'h090807060504030201);

    // T2: second window parks in the accumulator, then one load moves it up
    for (int i = 10; i <= 18; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t2_ready_low", bus_ready, 0);
    chk("t2_bdr", bus_data_ready, 1);
    chk("t2_window_held", window_out, 72'h090807060504030201);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_window", window_out, 72'h1211100F0E0D0C0B0A);
    chk("t2_bdr_stays", bus_data_ready, 1);
    chk("t2_count", win_count, 1);
    chk("t2_ready", bus_ready, 1);

    // T3: load on the same edge as the 9th pixel of the next window
    for (int i = 8'h13; i <= 8'h1A; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h1B, 1'b1, 1'b0);
    chk("t3_bdr_no_gap", bus_data_ready, 1);
    chk("t3_window", window_out, 72'h1B1A19181716151413);
    chk("t3_count", win_count, 2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_bdr_drop", bus_data_ready, 0);
    chk("t3_count2", win_count, 3);
    chk("t3_window_kept", window_out, 72'h1B1A19181716151413);

    // T4: spurious load, then clear (with a pixel and load that must be discarded)
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_spurious", spurious_load, 1);
    chk("t4_count", win_count, 3);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("t4_clr_spurious", spurious_load, 0);
    chk("t4_clr_count", win_count, 0);
    chk("t4_clr_bdr", bus_data_ready, 0);
    chk("t4_clr_ready", bus_ready, 1);
    for (int i = 8'h21; i <= 8'h29; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t4_window", window_out, 72'h292827262524232221);
    chk("t4_bdr", bus_data_ready, 1);

    // T5: async reset in the middle of a partial window
    for (int i = 8'hA1; i <= 8'hA5; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("t5_bdr", bus_data_ready, 0);
    chk("t5_window", window_out, 0);
    chk("t5_ready", bus_ready, 1);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 8'hB1; i <= 8'hB9; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i < 8'hB9) chk("t5_bdr_low", bus_data_ready, 0);
    end
    chk("t5_new_window", window_out, 72'hB9B8B7B6B5B4B3B2B1);
    chk("t5_new_bdr", bus_data_ready, 1);

    // T6: random valid/load stream against a window queue
    step(1'b0, 8'h00, 1'b0, 1'b1);
    exp_q.delete();
    build = '0; pix = 8'h40; cnt = 0; consumed = 0;
    for (int c = 0; c < 3000 && consumed < 30; c++) begin
      @(negedge clk);
      v      = 1'($urandom_range(0, 1));
      ld     = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      acc_ok = v && (exp_q.size() < 2);
      if (ld) begin
        chk("t6_window", window_out, exp_q.pop_front());
        consumed++;
      end
      bus_valid   = v;
      bus_data    = pix;
      load_enable = ld;
      @(posedge clk);
      #1;
      bus_valid   = 1'b0;
      load_enable = 1'b0;
      if (acc_ok) begin
        build[cnt*8 +: 8] = pix;
        pix++;
        cnt++;
        if (cnt == 9) begin
          exp_q.push_back(build);
          cnt = 0;
        end
      end
      chk("t6_bdr", bus_data_ready, (exp_q.size() > 0) ? 1 : 0);
      chk("t6_ready", bus_ready, (exp_q.size() < 2) ? 1 : 0);
    end
    chk("t6_consumed", consumed, 30);
    chk("t6_count", win_count, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
